mouse_pos_ctl: RTL
==================

Name: mouse_pos_ctl

Overview:
Conditions raw mouse data from the PS/2 mouse controller before it reaches the crosshair overlay stage. It synchronises position and left-button inputs and clamps the position so the 16x16 plus never wraps. Position is updated once per frame, at vblank start, so the cursor never tears mid-frame. A one-cycle "shot" pulse carries the hit coordinates, and a per-shot cooldown is counted in frames.

Parameters:
H_MAX, 799, last visible hcount
V_MAX, 599, last visible vcount
MARGIN, 7, crosshair half-size; clamp range is [MARGIN, H_MAX-MARGIN] and [MARGIN, V_MAX-MARGIN]
RST_X, 400, xpos reset value
RST_Y, 300, ypos reset value
COOLDOWN_FRAMES, 15, frames after button release before a new shot is accepted (0 allowed)

Ports:
clk  in  1  pixel clock; the single clock of the block
rst  in  1  reset, asynchronous, active-high
xpos_raw  in  12  mouse controller X, may be asynchronous to clk
ypos_raw  in  12  mouse controller Y, may be asynchronous to clk
left_raw  in  1  left button, asynchronous
vblnk  in  1  vertical blank from VGA timing
xpos  out  12  frame-stable, clamped X to the overlay stage
ypos  out  12  frame-stable, clamped Y to the overlay stage
shot  out  1  one-cycle shot pulse
shot_x  out  12  xpos captured at shot; held until the next shot
shot_y  out  12  ypos captured at shot; held until the next shot
ready  out  1  1 when a new press will fire (FSM in IDLE)

Behaviour:
- Reset values (asynchronous): xpos=RST_X, ypos=RST_Y, pending=(RST_X,RST_Y), shot=0, shot_x=0, shot_y=0, ready=1, state=IDLE, cooldown counter=0, all sync flops=0.
- Position sync:
  - Two register stages s1 and s2 per axis.
  - Every edge: if s1==s2 then pending<=s2; otherwise pending holds. This rejects torn multi-bit samples.
  - A stable raw value reaches pending 3 edges after it is first sampled.
- Frame latch:
  - vblnk is registered as vblnk_d; frame start is vblnk & ~vblnk_d.
  - On frame start, xpos<=clamp(pending_x) and ypos<=clamp(pending_y). The latch uses the pre-edge value of pending.
  - xpos and ypos change at no other time.
- Clamp, unsigned 12-bit:
  - v<MARGIN gives MARGIN.
  - v>MAX-MARGIN gives MAX-MARGIN.
  - Otherwise v.
- Button sync:
  - left_raw passes through 2 flops to give left_s; left_d is a register of left_s.
  - press = left_s & ~left_d.
- FSM (registered outputs):
  - IDLE: ready=1. On press, go to FIRE.
  - FIRE: lasts 1 cycle, shot=1, shot_x/shot_y<=current xpos/ypos. Then go to HOLD.
  - HOLD: wait for left_s==0, then go to COOLDOWN with counter=0.
  - COOLDOWN:
    - Counter increments on each frame start.
    - When counter==COOLDOWN_FRAMES, go to IDLE.
    - With COOLDOWN_FRAMES=0, return to IDLE on the next edge.
    - A press during COOLDOWN is ignored, not queued.
- Latency: if left_raw is 1 at edge k, shot=1 from edge k+3 to edge k+4, exactly one cycle.
- A button held through reset release produces no shot until it is released and pressed again (requires a 0->1 edge on left_s).
- shot coincident with frame start: shot_x/y take the pre-edge xpos/ypos.
- Counter width is ceil(log2(COOLDOWN_FRAMES+1)), minimum 1; it never wraps.
- Reset mid-operation: everything returns to reset values immediately, and no shot pulse is emitted.

Test Plan:
1. Reset, then hold xpos_raw=100, ypos_raw=200 and pulse vblnk 0->1 -> xpos/ypos stay 400/300 until the frame start, then become 100/200 one cycle after.
2. xpos_raw=2, ypos_raw=4000, frame start -> xpos=7, ypos=592; xpos_raw=795 -> xpos=792.
3. Toggle xpos_raw each cycle between 0x0FF and 0x100 -> pending never changes; then hold 0x100 -> xpos=0x100 after the next frame start.
4. left_raw 0->1 at edge k, current xpos=300, ypos=250 -> shot=1 for exactly cycle k+3, shot_x=300, shot_y=250, ready=0 from k+3.
5. Release the button, press again after 5 frames (COOLDOWN_FRAMES=15) -> no shot. After 15 frame starts, ready=1 and the next press fires.
6. left_raw=1 held through reset release -> no shot; then release and press -> one shot. Assert rst during HOLD -> ready=1 and shot=0 immediately.

Source files
------------

// File: rtl/mouse_pos_ctl.sv
// mouse_pos_ctl: conditions raw PS/2 mouse position and left button for the
// crosshair overlay. Position is synchronised, clamped so the 16x16 plus never
// wraps, and updated once per frame at vblank start. A press fires a one-cycle
// shot carrying the hit coordinates, followed by a frame-counted cooldown.
module mouse_pos_ctl #(
    parameter int unsigned H_MAX           = 799,
    parameter int unsigned V_MAX           = 599,
    parameter int unsigned MARGIN          = 7,
    parameter int unsigned RST_X           = 400,
    parameter int unsigned RST_Y           = 300,
    parameter int unsigned COOLDOWN_FRAMES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos_raw,
    input  logic [11:0] ypos_raw,
    input  logic        left_raw,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        shot,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y,
    output logic        ready
);

    localparam int unsigned CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [11:0]      X_LO     = 12'(MARGIN);
    localparam logic [11:0]      X_HI     = 12'(H_MAX - MARGIN);
    localparam logic [11:0]      Y_LO     = 12'(MARGIN);
    localparam logic [11:0]      Y_HI     = 12'(V_MAX - MARGIN);
    localparam logic [11:0]      X_RST    = 12'(RST_X);
    localparam logic [11:0]      Y_RST    = 12'(RST_Y);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        HOLD,
        COOLDOWN
    } state_t;

    function automatic logic [11:0] clamp(input logic [11:0] v,
                                          input logic [11:0] lo,
                                          input logic [11:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // Position synchroniser, torn-sample filter and frame-stable outputs
    logic [11:0] xs1_q, xs1_d, xs2_q, xs2_d;
    logic [11:0] ys1_q, ys1_d, ys2_q, ys2_d;
    logic [11:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic        vblnk_dly_q, vblnk_dly_d;

    // Button synchroniser, edge detector and post-reset arming
    logic        l1_q, l1_d, left_s_q, left_s_d, left_d_q, left_d_d;
    logic [1:0]  fill_q, fill_d;
    logic        armed_q, armed_d;

    // Shot FSM and its registered outputs
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               shot_q, shot_d, ready_q, ready_d;
    logic [11:0]        shot_x_q, shot_x_d, shot_y_q, shot_y_d;

    logic frame_start;
    logic press;

    assign frame_start = vblnk & ~vblnk_dly_q;
    // The arm flag stops a button held through reset from looking like a fresh press
    assign press       = left_s_q & ~left_d_q & armed_q;

    // Next values for the synchronisers, the stable-sample filter and the frame latch
    always_comb begin
        xs1_d       = xpos_raw;
        xs2_d       = xs1_q;
        ys1_d       = ypos_raw;
        ys2_d       = ys1_q;
        pend_x_d    = (xs1_q == xs2_q) ? xs2_q : pend_x_q;
        pend_y_d    = (ys1_q == ys2_q) ? ys2_q : pend_y_q;
        vblnk_dly_d = vblnk;
        xpos_d      = frame_start ? clamp(pend_x_q, X_LO, X_HI) : xpos_q;
        ypos_d      = frame_start ? clamp(pend_y_q, Y_LO, Y_HI) : ypos_q;
        l1_d        = left_raw;
        left_s_d    = l1_q;
        left_d_d    = left_s_q;
        fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d     = armed_q | ((fill_q == 2'd2) & ~left_s_q);
    end

    // Datapath and synchroniser registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs1_q       <= '0;
            xs2_q       <= '0;
            ys1_q       <= '0;
            ys2_q       <= '0;
            pend_x_q    <= X_RST;
            pend_y_q    <= Y_RST;
            vblnk_dly_q <= 1'b0;
            xpos_q      <= X_RST;
            ypos_q      <= Y_RST;
            l1_q        <= 1'b0;
            left_s_q    <= 1'b0;
            left_d_q    <= 1'b0;
            fill_q      <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            xs1_q       <= xs1_d;
            xs2_q       <= xs2_d;
            ys1_q       <= ys1_d;
            ys2_q       <= ys2_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            vblnk_dly_q <= vblnk_dly_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            l1_q        <= l1_d;
            left_s_q    <= left_s_d;
            left_d_q    <= left_d_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
        end
    end

    // FSM state and cooldown counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; the counter stops at its limit so it never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (press) state_d = FIRE;
            end
            FIRE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!left_s_q) begin
                    state_d = COOLDOWN;
                    cnt_d   = '0;
                end
            end
            COOLDOWN: begin
                if (cnt_q == CNT_LAST) state_d = IDLE;
                else if (frame_start)  cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs, registered one cycle behind the state
    always_comb begin
        shot_d   = (state_q == FIRE);
        ready_d  = (state_q == IDLE);
        shot_x_d = (state_q == FIRE) ? xpos_q : shot_x_q;
        shot_y_d = (state_q == FIRE) ? ypos_q : shot_y_q;
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shot_q   <= 1'b0;
            ready_q  <= 1'b1;
            shot_x_q <= '0;
            shot_y_q <= '0;
        end else begin
            shot_q   <= shot_d;
            ready_q  <= ready_d;
            shot_x_q <= shot_x_d;
            shot_y_q <= shot_y_d;
        end
    end

    assign xpos   = xpos_q;
    assign ypos   = ypos_q;
    assign shot   = shot_q;
    assign shot_x = shot_x_q;
    assign shot_y = shot_y_q;
    assign ready  = ready_q;

endmodule
